seq_mul_add_reconstructor: RTL

//   Sequential shift-add unit computing dividend = quotient*divisor + remainder.

---
 rtl/divrec_pkg.sv | 16 +
 rtl/seq_mul_add_reconstructor_datapath.sv | 35 +++
 rtl/seq_mul_add_reconstructor.sv | 96 +++++++++
 3 files changed

// File: rtl/divrec_pkg.sv
// Shared encodings and sizing helpers for the divider and its reconstructor.
package divrec_pkg;
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int N_DEF = 4;
    localparam int CNT_W = $clog2(N_DEF);

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/seq_mul_add_reconstructor_datapath.sv
// Shift-add datapath: acc accumulates the shifted multiplicand for each set
// multiplier bit, starting from the addend.
module shift_add_datapath #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   mplier_in,
    input  logic [N-1:0]   mcand_in,
    input  logic [N-1:0]   addend,
    output logic [2*N-1:0] acc
);
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;

    // 2N bits cover (2^N-1)^2 + 2^N-1, so the sum never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= {{N{1'b0}}, addend};
            mcand  <= {{N{1'b0}}, mcand_in};
            mplier <= mplier_in;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/seq_mul_add_reconstructor.sv
// Rebuilds dividend = quotient*divisor + remainder over N shift-add steps.
// Optional REM_CHECK_EN adds rem_err flagging remainder >= nonzero divisor.
module seq_mul_add_reconstructor
    import divrec_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   quotient,
    input  logic [N-1:0]   divisor,
    input  logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] dividend
`ifdef REM_CHECK_EN
    ,
    output logic           rem_err
`endif
);
    localparam int CW = cnt_w(N);

    state_t         state, nxt;
    logic [CW-1:0]  count;
    logic           load, step, last;
    logic [2*N-1:0] acc;

    assign last = (count == CW'(N-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        load = (state == IDLE) && start;
        step = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (load) count <= '0;
        else if (step) count <= count + 1'b1;
    end

    // Result is registered out of DONE, so done appears in the following IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            dividend <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE)
                dividend <= acc;
        end
    end

`ifdef REM_CHECK_EN
    logic rem_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_flag <= 1'b0;
            rem_err  <= 1'b0;
        end else begin
            if (load)
                rem_flag <= (divisor != '0) && (remainder >= divisor);
            if (state == DONE)
                rem_err <= rem_flag;
        end
    end
`endif

    shift_add_datapath #(.N(N)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .mplier_in (quotient),
        .mcand_in  (divisor),
        .addend    (remainder),
        .acc       (acc)
    );
endmodule
